// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and shared-FIFO write bus for fifo_wr_arbiter.
// The master modport is the producer/FIFO side; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   localparam int OW = $clog2(NREQ);

   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic               fifo_full;
   logic [NREQ-1:0]    gnt;
   logic               fifo_wr_en;
   logic [DW-1:0]      fifo_wr_data;
   logic [OW-1:0]      owner;
   logic               busy;

   modport master (
      output req, req_data, fifo_full,
      input  gnt, fifo_wr_en, fifo_wr_data, owner, busy
   );

   modport slave (
      input  req, req_data, fifo_full,
      output gnt, fifo_wr_en, fifo_wr_data, owner, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: N producers share one synchronous FIFO write port.
// Zero-latency grant; a granted port keeps the lock for up to BURST_MAX writes.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int BURST_MAX = 4,
   parameter int DW        = 8
) (
   input  logic             clk,
   input  logic             rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int OW = $clog2(NREQ);

   typedef enum logic {IDLE, BURST} state_e;

   state_e        state_q, state_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [3:0]    burst_cnt_q, burst_cnt_d;
   logic          busy_q, busy_d;

   logic          scan_vld;
   logic [OW-1:0] scan_idx;
   logic [NREQ-1:0] gnt_c;
   logic [DW-1:0]   wr_data_c;

   function automatic logic [OW-1:0] port_at(input logic [OW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return OW'(s);
   endfunction

   function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] p);
      return (p == OW'(NREQ - 1)) ? '0 : p + OW'(1);
   endfunction

   // Descending scan so the lowest offset from rr_ptr wins.
   always_comb begin
      scan_vld = 1'b0;
      scan_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req[port_at(rr_ptr_q, k)]) begin
            scan_vld = 1'b1;
            scan_idx = port_at(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gnt_c       = '0;
      case (state_q)
         IDLE: begin
            if (scan_vld && !bus.fifo_full) begin
               gnt_c[scan_idx] = 1'b1;
               if (BURST_MAX > 1) begin
                  state_d     = BURST;
                  owner_d     = scan_idx;
                  burst_cnt_d = 4'd1;
               end else begin
                  rr_ptr_d = wrap_inc(scan_idx);
               end
            end
         end
         BURST: begin
            if (!bus.req[owner_q]) begin
               state_d     = IDLE;
               rr_ptr_d    = wrap_inc(owner_q);
               owner_d     = '0;
               burst_cnt_d = '0;
            end else if (!bus.fifo_full) begin
               gnt_c[owner_q] = 1'b1;
               if (burst_cnt_q + 4'd1 == 4'(BURST_MAX)) begin
                  state_d     = IDLE;
                  rr_ptr_d    = wrap_inc(owner_q);
                  owner_d     = '0;
                  burst_cnt_d = '0;
               end else begin
                  burst_cnt_d = burst_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            owner_d     = '0;
            burst_cnt_d = '0;
         end
      endcase
      busy_d = (state_d == BURST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         busy_q      <= busy_d;
      end
   end

   // Reset gates the grant combinationally, independent of the flops.
   assign bus.gnt        = rst ? '0 : gnt_c;
   assign bus.fifo_wr_en = |(bus.req & bus.gnt);

   always_comb begin
      wr_data_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req[i] && bus.gnt[i]) wr_data_c = wr_data_c | bus.req_data[i*DW +: DW];
      end
   end

   assign bus.fifo_wr_data = wr_data_c;
   assign bus.owner        = owner_q;
   assign bus.busy         = busy_q;

   gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
   no_wr_full_a: assert property (@(posedge clk) disable iff (rst) bus.fifo_full |-> !bus.fifo_wr_en);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration model and a 3-deep FIFO scoreboard.
module tb_fifo_wr_arbiter;
   localparam int N     = 4;
   localparam int BM    = 4;
   localparam int DW    = 8;
   localparam int BOUND = (N - 1) * (BM + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cmp_cnt = 0;
   int   err_cnt = 0;

   fifo_wr_arbiter_if #(.NREQ(N), .DW(DW)) bus ();

   fifo_wr_arbiter #(.NREQ(N), .BURST_MAX(BM), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Port i presents 8'h05 + 16*i in the directed tests.
   localparam logic [N*DW-1:0] FIXED_DATA = 32'h35_25_15_05;

   task automatic drive(input logic [N-1:0] r, input logic f);
      @(negedge clk);
      bus.req       = r;
      bus.fifo_full = f;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.req       = '0;
      bus.fifo_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.req       = 4'b1111;
      bus.req_data  = FIXED_DATA;
      bus.fifo_full = 1'b0;
      #1;
      cmp_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
      cmp_cnt++; if (bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_en got=%b want=0", bus.fifo_wr_en); end
      cmp_cnt++; if (bus.fifo_wr_data !== 8'h00) begin err_cnt++; $display("FAIL reset_wr_data got=%h want=00", bus.fifo_wr_data); end
      cmp_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL reset_owner got=%0d want=0", bus.owner); end
      cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      @(negedge clk);
      bus.req = '0;
      rst     = 1'b0;
   endtask

   task automatic test_single_port();
      logic exp_busy;
      do_reset();
      bus.req_data = FIXED_DATA;
      for (int c = 0; c < 5; c++) begin
         drive(4'b0001, 1'b0);
         exp_busy = (c >= 1 && c <= 3);
         cmp_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL single_gnt c=%0d got=%b want=0001", c, bus.gnt); end
         cmp_cnt++; if (bus.fifo_wr_en !== 1'b1) begin err_cnt++; $display("FAIL single_wr_en c=%0d got=%b want=1", c, bus.fifo_wr_en); end
         cmp_cnt++; if (bus.fifo_wr_data !== 8'h05) begin err_cnt++; $display("FAIL single_data c=%0d got=%h want=05", c, bus.fifo_wr_data); end
         cmp_cnt++; if (bus.busy !== exp_busy) begin err_cnt++; $display("FAIL single_busy c=%0d got=%b want=%b", c, bus.busy, exp_busy); end
      end
   endtask

   task automatic test_all_ports();
      int e;
      logic [N-1:0] eg;
      logic [DW-1:0] ed;
      do_reset();
      bus.req_data = FIXED_DATA;
      for (int c = 0; c < 17; c++) begin
         drive(4'b1111, 1'b0);
         e  = (c < 16) ? c / 4 : 0;
         eg = 4'(1 << e);
         ed = 8'(5 + 16 * e);
         cmp_cnt++; if (bus.gnt !== eg) begin err_cnt++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, bus.gnt, eg); end
         cmp_cnt++; if (bus.fifo_wr_data !== ed) begin err_cnt++; $display("FAIL rr_data c=%0d got=%h want=%h", c, bus.fifo_wr_data, ed); end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      bus.req_data = FIXED_DATA;
      drive(4'b0100, 1'b0);
      drive(4'b0100, 1'b0);
      for (int c = 0; c < 3; c++) begin
         drive(4'b0100, 1'b1);
         cmp_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL stall_gnt c=%0d got=%b want=0000", c, bus.gnt); end
         cmp_cnt++; if (bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL stall_wr_en c=%0d got=%b want=0", c, bus.fifo_wr_en); end
         cmp_cnt++; if (bus.owner !== 2'd2) begin err_cnt++; $display("FAIL stall_owner c=%0d got=%0d want=2", c, bus.owner); end
         cmp_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL stall_busy c=%0d got=%b want=1", c, bus.busy); end
      end
      for (int c = 0; c < 2; c++) begin
         drive(4'b0100, 1'b0);
         cmp_cnt++; if (bus.gnt !== 4'b0100) begin err_cnt++; $display("FAIL resume_gnt c=%0d got=%b want=0100", c, bus.gnt); end
         cmp_cnt++; if (bus.fifo_wr_data !== 8'h25) begin err_cnt++; $display("FAIL resume_data c=%0d got=%h want=25", c, bus.fifo_wr_data); end
      end
      drive(4'b0000, 1'b0);
      cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL stall_end_busy got=%b want=0", bus.busy); end
      cmp_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL stall_end_owner got=%0d want=0", bus.owner); end
      cmp_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL stall_end_gnt got=%b want=0000", bus.gnt); end
   endtask

   task automatic test_drop();
      do_reset();
      bus.req_data = FIXED_DATA;
      drive(4'b0010, 1'b0);
      cmp_cnt++; if (bus.gnt !== 4'b0010) begin err_cnt++; $display("FAIL drop_first_gnt got=%b want=0010", bus.gnt); end
      drive(4'b1000, 1'b0);
      cmp_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL drop_idle_gnt got=%b want=0000", bus.gnt); end
      cmp_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL drop_busy got=%b want=1", bus.busy); end
      // Port 0 also requests: port 3 winning shows the pointer moved to 2.
      drive(4'b1001, 1'b0);
      cmp_cnt++; if (bus.gnt !== 4'b1000) begin err_cnt++; $display("FAIL drop_next_gnt got=%b want=1000", bus.gnt); end
      cmp_cnt++; if (bus.fifo_wr_data !== 8'h35) begin err_cnt++; $display("FAIL drop_next_data got=%h want=35", bus.fifo_wr_data); end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.req_data = FIXED_DATA;
      drive(4'b1000, 1'b0);
      drive(4'b1000, 1'b0);
      cmp_cnt++; if (bus.owner !== 2'd3) begin err_cnt++; $display("FAIL arst_pre_owner got=%0d want=3", bus.owner); end
      cmp_cnt++; if (bus.gnt !== 4'b1000) begin err_cnt++; $display("FAIL arst_pre_gnt got=%b want=1000", bus.gnt); end
      #2;
      rst = 1'b1;
      #1;
      cmp_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL arst_gnt got=%b want=0000", bus.gnt); end
      cmp_cnt++; if (bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL arst_wr_en got=%b want=0", bus.fifo_wr_en); end
      cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL arst_busy got=%b want=0", bus.busy); end
      cmp_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL arst_owner got=%0d want=0", bus.owner); end
      @(negedge clk);
      rst     = 1'b0;
      bus.req = 4'b1001;
      #1;
      cmp_cnt++; if (bus.gnt !== 4'b0001) begin err_cnt++; $display("FAIL arst_restart_gnt got=%b want=0001", bus.gnt); end
   endtask

   task automatic test_random();
      int occ;
      bit has [N];
      logic [DW-1:0] cur [N];
      int seq_prod [N];
      int seq_exp [N];
      int waitc [N];
      int m_hold, m_used, m_ptr, exp_port;
      logic full;
      logic [N-1:0] eg;
      logic [DW-1:0] ed;
      bit produce;

      do_reset();
      occ = 0; m_hold = -1; m_used = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin
         has[i] = 1'b0; cur[i] = '0; seq_prod[i] = 0; seq_exp[i] = 0; waitc[i] = 0;
      end

      for (int cyc = 0; cyc < 3200; cyc++) begin
         produce = (cyc < 3000);
         @(negedge clk);
         if (occ > 0 && (!produce || $urandom_range(0, 2) != 0)) occ--;
         for (int i = 0; i < N; i++) begin
            if (produce && !has[i] && $urandom_range(0, 3) == 0) begin
               has[i] = 1'b1;
               cur[i] = {2'(i), 6'(seq_prod[i])};
               seq_prod[i]++;
            end
            bus.req[i]             = has[i];
            bus.req_data[i*DW +: DW] = cur[i];
         end
         full          = (occ == 3);
         bus.fifo_full = full;
         #1;

         // Reference arbitration: lock holder keeps the port until it stops
         // requesting or has used its BM writes; otherwise first requester from m_ptr.
         exp_port = -1;
         if (m_hold < 0) begin
            if (!full) begin
               for (int k = 0; k < N; k++) begin
                  if (exp_port < 0 && has[(m_ptr + k) % N]) exp_port = (m_ptr + k) % N;
               end
            end
            if (exp_port >= 0) begin
               if (BM > 1) begin m_hold = exp_port; m_used = 1; end
               else m_ptr = (exp_port + 1) % N;
            end
         end else if (!has[m_hold]) begin
            m_ptr = (m_hold + 1) % N; m_hold = -1; m_used = 0;
         end else if (!full) begin
            exp_port = m_hold;
            m_used++;
            if (m_used == BM) begin m_ptr = (m_hold + 1) % N; m_hold = -1; m_used = 0; end
         end

         eg = (exp_port >= 0) ? 4'(1 << exp_port) : 4'b0000;
         cmp_cnt++; if (bus.gnt !== eg) begin err_cnt++; $display("FAIL rand_gnt cyc=%0d got=%b want=%b", cyc, bus.gnt, eg); end
         cmp_cnt++; if (bus.fifo_wr_en !== (exp_port >= 0)) begin err_cnt++; $display("FAIL rand_wr_en cyc=%0d got=%b want=%b", cyc, bus.fifo_wr_en, (exp_port >= 0)); end
         if (bus.fifo_wr_en) begin
            cmp_cnt++; if (occ >= 3) begin err_cnt++; $display("FAIL rand_write_full cyc=%0d occ=%0d want<3", cyc, occ); end
         end
         if (exp_port >= 0) begin
            ed = {2'(exp_port), 6'(seq_exp[exp_port])};
            cmp_cnt++; if (bus.fifo_wr_data !== ed) begin err_cnt++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, bus.fifo_wr_data, ed); end
            seq_exp[exp_port]++;
            has[exp_port] = 1'b0;
            if (occ < 3) occ++;
         end

         for (int i = 0; i < N; i++) begin
            if (i == exp_port || !bus.req[i]) waitc[i] = 0;
            else if (!full) begin
               waitc[i]++;
               cmp_cnt++; if (waitc[i] > BOUND) begin err_cnt++; $display("FAIL rand_wait port=%0d got=%0d want<=%0d", i, waitc[i], BOUND); end
            end
         end
      end

      for (int i = 0; i < N; i++) begin
         cmp_cnt++; if (seq_exp[i] != seq_prod[i] || has[i]) begin err_cnt++; $display("FAIL rand_drain port=%0d written=%0d produced=%0d pending=%0d", i, seq_exp[i], seq_prod[i], has[i]); end
      end
      @(negedge clk);
      bus.req = '0;
   endtask

   initial begin
      bus.req       = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      test_reset();
      test_single_port();
      test_all_ports();
      test_full_stall();
      test_drop();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL take parameter NREQ, default 4, number of producer ports (2..8).
REQ-002 The block SHALL take parameter BURST_MAX, default 4, max consecutive writes per grant (1..15).
REQ-003 The block SHALL take parameter DW, default 8, data width matching the shared FIFO.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-producer write request, held with data until granted.
REQ-007 req_data  input  NREQ*DW  flat producer data, port i at bits [i*DW +: DW].
REQ-008 fifo_full  input  1  full flag from shared synchronous FIFO.
REQ-009 gnt  output  NREQ  one-hot grant, combinational; port i transfers when req[i] and gnt[i].
REQ-010 fifo_wr_en  output  1  write strobe to FIFO, equals OR of (req & gnt).
REQ-011 fifo_wr_data  output  DW  req_data slice of granted port, all-zero when fifo_wr_en low.
REQ-012 owner  output  clog2(NREQ)  registered index of port holding the burst lock, 0 in IDLE.
REQ-013 busy  output  1  registered, high while FSM in BURST.

Function
REQ-014 FSM SHALL have two states: IDLE, BURST; registered state also includes rr_ptr (clog2(NREQ) bits) and burst_cnt (4 bits).
REQ-015 gnt SHALL be at most one-hot and SHALL be all-zero whenever fifo_full is high or rst is high.
REQ-016 IDLE: grant the first requesting port at or after rr_ptr, scanning upward with wrap from NREQ-1 to 0; no request -> gnt zero, stay IDLE.
REQ-017 IDLE grant with BURST_MAX>1 SHALL go to BURST next cycle with owner=granted port, burst_cnt=1.
REQ-018 IDLE grant with BURST_MAX=1 SHALL stay IDLE and set rr_ptr=(granted+1) mod NREQ.
REQ-019 BURST: gnt[owner]=req[owner] & ~fifo_full; other ports SHALL never be granted.
REQ-020 BURST transfer SHALL increment burst_cnt; when the incremented value equals BURST_MAX, go IDLE, rr_ptr=(owner+1) mod NREQ, burst_cnt=0.
REQ-021 BURST with req[owner] low SHALL go IDLE next cycle with rr_ptr=(owner+1) mod NREQ and no grant that cycle.
REQ-022 BURST with fifo_full high and req[owner] high SHALL hold state, owner and burst_cnt unchanged.
REQ-023 Transfer latency SHALL be zero cycles: data accepted in the cycle req, gnt and ~fifo_full coincide.
REQ-024 A port requesting continuously SHALL wait at most (NREQ-1)*(BURST_MAX+1) cycles of non-full FIFO before grant.
REQ-025 rr_ptr arithmetic SHALL wrap modulo NREQ, including non-power-of-two NREQ.

Reset
REQ-026 rst high SHALL asynchronously force state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, busy=0.
REQ-027 rst high SHALL force gnt=0, fifo_wr_en=0, fifo_wr_data=0 combinationally.
REQ-028 rst asserted mid-burst SHALL abandon the burst; after release, arbitration restarts from port 0.

Verification
REQ-029 NREQ=4, BURST_MAX=4, req=4'b0001 held, fifo_full=0 -> gnt=0001 four cycles with fifo_wr_en=1, busy=1 after first, fifth cycle IDLE grants port 0 again.
REQ-030 req=4'b1111 continuous, fifo_full=0 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0 (rr_ptr wraps 3 to 0).
REQ-031 Port 2 in BURST at burst_cnt=2, fifo_full=1 for 3 cycles -> gnt=0, fifo_wr_en=0, owner=2 held; after full drops two more port-2 writes then IDLE.
REQ-032 Port 1 in BURST drops req after 1 write while req[3] high -> one idle cycle, then gnt=1000 with rr_ptr having been 2.
REQ-033 rst pulsed asynchronously mid-burst on owner=3 -> gnt/fifo_wr_en low immediately, busy=0, owner=0; with req=4'b1001 after release port 0 granted first.
REQ-034 Scoreboard with 3-deep FIFO model, random req/fifo_full -> no write while full, no lost or duplicated word, per-port order preserved, REQ-024 wait bound never exceeded.
